// File: rtl/wdt_pkg.sv
// Shared types and defaults for the watchdog fault responder.
// Build option: define WDT_FAULT_LOG_EN to enable the trip counter in wdt_fault_responder.
package wdt_pkg;

    localparam int WDT_AMP_W_DEF       = 16;
    localparam int WDT_RAMP_STEP_DEF   = 4096;
    localparam int WDT_WARN_SHIFT_DEF  = 1;
    localparam int WDT_HOLD_CYCLES_DEF = 1024;

    // Responder states; RECOVER is the post-reset state so the carrier soft-starts.
    typedef enum logic [2:0] {
        WDT_IDLE    = 3'd0,
        WDT_WARN    = 3'd1,
        WDT_RAMP_DN = 3'd2,
        WDT_HOLD    = 3'd3,
        WDT_RECOVER = 3'd4
    } wdt_resp_state_t;

    // Command to the gain ramp register for the next cycle.
    typedef enum logic [1:0] {
        RAMP_OP_KEEP = 2'd0,
        RAMP_OP_UP   = 2'd1,
        RAMP_OP_DN   = 2'd2,
        RAMP_OP_LOAD = 2'd3
    } ramp_op_t;

    // Saturating 8-bit increment for event counters.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/wdt_fault_responder_gain_ramp.sv
// Saturating up/down gain register. The up/down candidates are exported so the
// controlling FSM can decide transitions on the value the register is about to take.
module gain_ramp
    import wdt_pkg::*;
#(
    parameter int AMP_W = WDT_AMP_W_DEF,
    parameter int STEP  = WDT_RAMP_STEP_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  ramp_op_t         i_op,
    input  logic [AMP_W-1:0] i_load_val,
    output logic [AMP_W-1:0] o_gain,
    output logic [AMP_W-1:0] o_up_val,
    output logic [AMP_W-1:0] o_dn_val
);

    localparam logic [AMP_W-1:0] GMAX   = {AMP_W{1'b1}};
    localparam logic [AMP_W:0]   GMAX_X = {1'b0, GMAX};
    localparam logic [AMP_W:0]   STEP_X = (AMP_W + 1)'(STEP);

    logic [AMP_W-1:0] r_gain;
    logic [AMP_W:0]   w_gain_x;
    logic [AMP_W:0]   w_sum;
    logic [AMP_W:0]   w_diff;
    logic [AMP_W-1:0] w_next;

    // Candidate values computed one bit wider so neither direction can wrap.
    always_comb begin
        w_gain_x = {1'b0, r_gain};
        w_sum    = w_gain_x + STEP_X;
        w_diff   = w_gain_x - STEP_X;
        if (w_sum > GMAX_X) begin
            o_up_val = GMAX;
        end else begin
            o_up_val = w_sum[AMP_W-1:0];
        end
        if (w_gain_x > STEP_X) begin
            o_dn_val = w_diff[AMP_W-1:0];
        end else begin
            o_dn_val = {AMP_W{1'b0}};
        end
    end

    // Select the next gain according to the requested operation.
    always_comb begin
        w_next = r_gain;
        case (i_op)
            RAMP_OP_KEEP: w_next = r_gain;
            RAMP_OP_UP:   w_next = o_up_val;
            RAMP_OP_DN:   w_next = o_dn_val;
            RAMP_OP_LOAD: w_next = i_load_val;
            default:      w_next = {AMP_W{1'b0}};
        endcase
    end

    // Gain register; starts silent so the carrier soft-starts out of reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_gain <= {AMP_W{1'b0}};
        end else begin
            r_gain <= w_next;
        end
    end

    assign o_gain = r_gain;

endmodule

// File: rtl/wdt_fault_responder.sv
// Watchdog alarm consumer: attenuates the AM carrier on warning, ramps it to zero
// on a trip, pulses the DSP-chain reset, then soft-starts the carrier again.
// Build option: WDT_FAULT_LOG_EN enables the saturating trip counter on fault_count.
module wdt_fault_responder
    import wdt_pkg::*;
#(
    parameter int AMP_W       = WDT_AMP_W_DEF,
    parameter int RAMP_STEP   = WDT_RAMP_STEP_DEF,
    parameter int WARN_SHIFT  = WDT_WARN_SHIFT_DEF,
    parameter int HOLD_CYCLES = WDT_HOLD_CYCLES_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             warning,
    input  logic             force_reset,
    output logic [AMP_W-1:0] gain,
    output logic             sys_rst_n_o,
    output logic             fault_active,
    output logic [7:0]       fault_count
);

    localparam logic [AMP_W-1:0] GMAX      = {AMP_W{1'b1}};
    localparam logic [AMP_W-1:0] GWARN     = GMAX >> WARN_SHIFT;
    localparam int               HC_W      = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);

    wdt_resp_state_t  r_state;
    wdt_resp_state_t  w_state_nxt;
    logic [HC_W-1:0]  r_hold_cnt;
    logic [HC_W-1:0]  w_hold_cnt_nxt;
    logic             r_sys_rst_n;
    logic             r_fault_active;
    logic             w_fault_active_nxt;
    ramp_op_t         w_op;
    logic [AMP_W-1:0] w_load_val;
    logic [AMP_W-1:0] w_gain;
    logic [AMP_W-1:0] w_up_val;
    logic [AMP_W-1:0] w_dn_val;

    gain_ramp #(
        .AMP_W (AMP_W),
        .STEP  (RAMP_STEP)
    ) u_gain_ramp (
        .clk        (clk),
        .rstn       (rstn),
        .i_op       (w_op),
        .i_load_val (w_load_val),
        .o_gain     (w_gain),
        .o_up_val   (w_up_val),
        .o_dn_val   (w_dn_val)
    );

    // Next-state, gain command and hold-count decode; force_reset always wins over warning.
    always_comb begin
        w_state_nxt    = r_state;
        w_op           = RAMP_OP_KEEP;
        w_load_val     = {AMP_W{1'b0}};
        w_hold_cnt_nxt = {HC_W{1'b0}};
        case (r_state)
            WDT_IDLE: begin
                if (force_reset) begin
                    w_state_nxt = WDT_RAMP_DN;
                    w_op        = RAMP_OP_DN;
                end else if (warning) begin
                    w_state_nxt = WDT_WARN;
                    w_op        = RAMP_OP_LOAD;
                    w_load_val  = GWARN;
                end else begin
                    w_op        = RAMP_OP_LOAD;
                    w_load_val  = GMAX;
                end
            end
            WDT_WARN: begin
                if (force_reset) begin
                    w_state_nxt = WDT_RAMP_DN;
                    w_op        = RAMP_OP_DN;
                end else if (!warning) begin
                    w_state_nxt = WDT_IDLE;
                    w_op        = RAMP_OP_LOAD;
                    w_load_val  = GMAX;
                end else begin
                    w_op        = RAMP_OP_LOAD;
                    w_load_val  = GWARN;
                end
            end
            WDT_RAMP_DN: begin
                // Inputs are ignored until the carrier is fully off.
                w_op = RAMP_OP_DN;
                if (w_dn_val == {AMP_W{1'b0}}) begin
                    w_state_nxt = WDT_HOLD;
                end else begin
                    w_state_nxt = WDT_RAMP_DN;
                end
            end
            WDT_HOLD: begin
                // Fixed-length hold: a trip still asserted is handled in RECOVER instead.
                w_op       = RAMP_OP_LOAD;
                w_load_val = {AMP_W{1'b0}};
                if (r_hold_cnt == HOLD_LAST) begin
                    w_state_nxt = WDT_RECOVER;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt + {{(HC_W-1){1'b0}}, 1'b1};
                end
            end
            WDT_RECOVER: begin
                if (force_reset) begin
                    w_state_nxt = WDT_RAMP_DN;
                    w_op        = RAMP_OP_DN;
                end else if (w_up_val == GMAX) begin
                    w_op = RAMP_OP_LOAD;
                    if (warning) begin
                        w_state_nxt = WDT_WARN;
                        w_load_val  = GWARN;
                    end else begin
                        w_state_nxt = WDT_IDLE;
                        w_load_val  = GMAX;
                    end
                end else begin
                    w_op = RAMP_OP_UP;
                end
            end
            default: begin
                // Illegal encoding: silence the carrier and soft-start again.
                w_state_nxt = WDT_RECOVER;
                w_op        = RAMP_OP_LOAD;
                w_load_val  = {AMP_W{1'b0}};
            end
        endcase
    end

    // Fault indication follows the state being entered so it lines up with gain.
    always_comb begin
        w_fault_active_nxt = 1'b0;
        case (w_state_nxt)
            WDT_RAMP_DN, WDT_HOLD, WDT_RECOVER: w_fault_active_nxt = 1'b1;
            default:                            w_fault_active_nxt = 1'b0;
        endcase
    end

    // State, hold counter and registered status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state        <= WDT_RECOVER;
            r_hold_cnt     <= {HC_W{1'b0}};
            r_sys_rst_n    <= 1'b1;
            r_fault_active <= 1'b1;
        end else begin
            r_state        <= w_state_nxt;
            r_hold_cnt     <= w_hold_cnt_nxt;
            r_sys_rst_n    <= (w_state_nxt != WDT_HOLD);
            r_fault_active <= w_fault_active_nxt;
        end
    end

`ifdef WDT_FAULT_LOG_EN
    logic       w_trip;
    logic [7:0] r_fault_count;

    assign w_trip = (w_state_nxt == WDT_RAMP_DN) && (r_state != WDT_RAMP_DN);

    // Trip counter: counts entries into ramp-down, saturating, cleared only by rstn.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fault_count <= 8'd0;
        end else if (w_trip) begin
            r_fault_count <= sat_inc8(r_fault_count);
        end else begin
            r_fault_count <= r_fault_count;
        end
    end

    assign fault_count = r_fault_count;
`else
    assign fault_count = 8'd0;
`endif

    assign gain         = w_gain;
    assign sys_rst_n_o  = r_sys_rst_n;
    assign fault_active = r_fault_active;

endmodule

// File: tb/tb_wdt_fault_responder.sv
// Self-checking bench for wdt_fault_responder (AMP_W=16, STEP=4096, WARN_SHIFT=1, HOLD=8).
module tb_wdt_fault_responder;

    typedef struct {
        logic        w;
        logic        f;
        logic [15:0] g;
        logic        s;
        logic        fa;
    } vec_t;

    typedef struct {
        logic [15:0] g;
        logic        s;
        logic        fa;
    } exp_t;

`ifdef WDT_FAULT_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstn;
    logic        warning;
    logic        force_reset;
    logic [15:0] gain;
    logic        sys_rst_n_o;
    logic        fault_active;
    logic [7:0]  fault_count;

    int   errors = 0;
    int   checks = 0;
    vec_t vecs[$];
    exp_t sb[$];

    wdt_fault_responder #(
        .AMP_W       (16),
        .RAMP_STEP   (4096),
        .WARN_SHIFT  (1),
        .HOLD_CYCLES (8)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .warning      (warning),
        .force_reset  (force_reset),
        .gain         (gain),
        .sys_rst_n_o  (sys_rst_n_o),
        .fault_active (fault_active),
        .fault_count  (fault_count)
    );

    always #5 clk = ~clk;

    function automatic int exp_cnt(input int trips);
        if (!LOG_EN) return 0;
        return (trips > 255) ? 255 : trips;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic w, input logic f, input int g, input logic s, input logic fa);
        vec_t v;
        v.w  = w;
        v.f  = f;
        v.g  = 16'(g);
        v.s  = s;
        v.fa = fa;
        vecs.push_back(v);
    endtask

    // Eight HOLD cycles (the entering one is added by the caller) then RECOVER at gain 0.
    task automatic add_hold_tail(input logic w);
        for (int k = 0; k < 7; k++) add(w, 1'b0, 0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 0, 1'b1, 1'b1);
    endtask

    task automatic add_full_ramp_up();
        for (int k = 1; k <= 16; k++)
            add(1'b0, 1'b0, (k < 16) ? 4096 * k : 65535, 1'b1, (k < 16) ? 1'b1 : 1'b0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        exp_t e;
        warning     = v.w;
        force_reset = v.f;
        e.g  = v.g;
        e.s  = v.s;
        e.fa = v.fa;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("vec%0d_sb_empty", idx), 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk($sformatf("vec%0d_gain", idx), 32'(gain), 32'(e.g));
            chk($sformatf("vec%0d_sys_rst_n", idx), 32'(sys_rst_n_o), 32'(e.s));
            chk($sformatf("vec%0d_fault_active", idx), 32'(fault_active), 32'(e.fa));
        end
    endtask

    initial begin
        int n;
        int run;
        int nruns;
        int gmax_seen;

        // ---------------- stimulus table ----------------
        // Soft start out of reset.
        add_full_ramp_up();
        // Warning pulse of three cycles.
        for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 32767, 1'b1, 1'b0);
        add(1'b0, 1'b0, 65535, 1'b1, 1'b0);
        // One-cycle trip from IDLE: 16 steps down, 8 cycles of hold, ramp-up.
        for (int k = 1; k <= 16; k++)
            add((k == 1) ? 1'b0 : 1'b0, (k == 1) ? 1'b1 : 1'b0,
                (k < 16) ? 65535 - 4096 * k : 0, (k < 16) ? 1'b1 : 1'b0, 1'b1);
        add_hold_tail(1'b0);
        add_full_ramp_up();
        // Warning and trip together: trip wins, warning ignored while ramping down.
        for (int k = 1; k <= 16; k++)
            add(1'b1, (k == 1) ? 1'b1 : 1'b0,
                (k < 16) ? 65535 - 4096 * k : 0, (k < 16) ? 1'b1 : 1'b0, 1'b1);
        add_hold_tail(1'b1);
        for (int k = 1; k <= 5; k++) add(1'b0, 1'b0, 4096 * k, 1'b1, 1'b1);
        // Trip mid-recovery at 20480.
        add(1'b0, 1'b1, 16384, 1'b1, 1'b1);
        add(1'b0, 1'b0, 12288, 1'b1, 1'b1);
        add(1'b0, 1'b0, 8192, 1'b1, 1'b1);
        add(1'b0, 1'b0, 4096, 1'b1, 1'b1);
        add(1'b0, 1'b0, 0, 1'b0, 1'b1);
        add_hold_tail(1'b0);
        for (int k = 1; k <= 15; k++) add(1'b0, 1'b0, 4096 * k, 1'b1, 1'b1);
        // Reaching full scale with warning high lands in WARN.
        add(1'b1, 1'b0, 32767, 1'b1, 1'b0);
        add(1'b0, 1'b0, 65535, 1'b1, 1'b0);

        // ---------------- reset ----------------
        rstn        = 1'b0;
        warning     = 1'b0;
        force_reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_gain", 32'(gain), 32'd0);
        chk("reset_sys_rst_n", 32'(sys_rst_n_o), 32'd1);
        chk("reset_fault_active", 32'(fault_active), 32'd1);
        chk("reset_fault_count", 32'(fault_count), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // ---------------- table-driven run ----------------
        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);
        chk("fault_count_after_table", 32'(fault_count), 32'(exp_cnt(3)));

        // ---------------- rstn asserted during HOLD ----------------
        force_reset = 1'b1;
        @(posedge clk);
        #1;
        force_reset = 1'b0;
        n = 0;
        while (sys_rst_n_o !== 1'b0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("hold_reached", 32'(n < 40), 32'd1);
        @(posedge clk);
        #1;
        chk("fault_count_before_rst", 32'(fault_count), 32'(exp_cnt(4)));
        chk("in_hold_sys_rst_n", 32'(sys_rst_n_o), 32'd0);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_gain", 32'(gain), 32'd0);
        chk("async_rst_sys_rst_n", 32'(sys_rst_n_o), 32'd1);
        chk("async_rst_fault_active", 32'(fault_active), 32'd1);
        chk("async_rst_fault_count", 32'(fault_count), 32'd0);
        @(negedge clk);
        rstn = 1'b1;

        // ---------------- force_reset held: repeated trips, fixed hold ----------------
        force_reset = 1'b1;
        run       = 0;
        nruns     = 0;
        gmax_seen = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            if (int'(gain) > gmax_seen) gmax_seen = int'(gain);
            if (sys_rst_n_o === 1'b0) begin
                run++;
            end else begin
                if (run > 0) begin
                    if (nruns < 4) chk($sformatf("held_hold_len%0d", nruns), 32'(run), 32'd8);
                    nruns++;
                end
                run = 0;
            end
        end
        force_reset = 1'b0;
        chk("held_repeat_trips", 32'(nruns >= 256), 32'd1);
        chk("held_gain_zero", 32'(gmax_seen), 32'd0);
        chk("fault_count_saturated", 32'(fault_count), 32'(exp_cnt(nruns + 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
